// File: rtl/turf_surf_cmd_serializer.sv
// TURF -> SURF command serializer: START, BUF, EVID (+PARITY) MSB first.
// Optional trailing parity bit enabled by defining TURF_CMD_PARITY_EN.
module turf_surf_cmd_serializer #(
  parameter int NUM_SURFS  = 12,
  parameter int GAP_CYCLES = 4
) (
  input  logic                 clk33_i,
  input  logic                 rst_n_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [31:0]          cmd_evid_i,
  input  logic [1:0]           cmd_buf_i,
  input  logic [NUM_SURFS-1:0] surf_mask_i,
  input  logic                 clr_all_i,
  output logic [NUM_SURFS-1:0] CMD_o,
  output logic                 busy_o,
  output logic [15:0]          frame_count_o
);

`ifdef TURF_CMD_PARITY_EN
  localparam int FRAME_LEN = 36;
`else
  localparam int FRAME_LEN = 35;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [5:0]           bit_cnt;
  logic [3:0]           gap_cnt;
  logic [FRAME_LEN-1:0] shreg;
  logic [FRAME_LEN-1:0] frame_w;
  logic [NUM_SURFS-1:0] mask_q;
  logic [NUM_SURFS-1:0] cmd_q;
  logic [15:0]          frame_cnt;
  logic                 ready_q;
  logic                 accept;

  assign accept = cmd_valid_i && ready_q;

`ifdef TURF_CMD_PARITY_EN
  assign frame_w = {1'b1, cmd_buf_i, cmd_evid_i,
                    ^{cmd_buf_i, cmd_evid_i}};
`else
  assign frame_w = {1'b1, cmd_buf_i, cmd_evid_i};
`endif

  // State register
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; clear overrides everything
  always_comb begin
    state_d = state_q;
    if (clr_all_i) begin
      state_d = GAP;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_d = SHIFT;
        SHIFT:   if (bit_cnt == 6'd0) state_d = GAP;
        GAP:     if (gap_cnt == 4'd0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs derived from state
  always_comb begin
    busy_o        = (state_q != IDLE);
    cmd_ready_o   = ready_q;
    CMD_o         = cmd_q;
    frame_count_o = frame_cnt;
  end

  // Datapath: latch command, shift bits out, count gap and frames
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_q   <= 1'b0;
      cmd_q     <= '0;
      shreg     <= '0;
      mask_q    <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      ready_q <= (state_d == IDLE);
      if (clr_all_i) begin
        cmd_q   <= '0;
        shreg   <= '0;
        gap_cnt <= 4'(GAP_CYCLES - 1);
      end else begin
        unique case (state_q)
          IDLE: begin
            cmd_q <= '0;
            if (accept) begin
              shreg   <= frame_w;
              mask_q  <= surf_mask_i;
              bit_cnt <= 6'(FRAME_LEN - 1);
            end
          end
          SHIFT: begin
            cmd_q   <= {NUM_SURFS{shreg[FRAME_LEN-1]}} & ~mask_q;
            shreg   <= {shreg[FRAME_LEN-2:0], 1'b0};
            bit_cnt <= bit_cnt - 6'd1;
            if (bit_cnt == 6'd0) begin
              gap_cnt   <= 4'(GAP_CYCLES - 1);
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
          GAP: begin
            cmd_q <= '0;
            if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
          end
          default: cmd_q <= '0;
        endcase
      end
    end
  end

endmodule
